// File: rtl/crypto_pkg.sv
// ----------------------------------------------------------------------------
// crypto_pkg
// Shared constants and types for the register file and its write-port
// controller. The regfile and regfile_wb_arbiter both import this package, so
// they always agree on the address and data widths.
//
// Contents:
//   ADDR_W, DATA_W, NUM_REGS : register file geometry
//   NUM_REQ_DEFAULT          : default number of writeback requesters
//   regAddr_t, regData_t     : register address and data types
//   wbWrite_t                : one registered regfile write (enable/addr/data)
// ----------------------------------------------------------------------------
package crypto_pkg;

   localparam int ADDR_W          = 5;
   localparam int DATA_W          = 32;
   localparam int NUM_REGS        = 2 ** ADDR_W;
   localparam int NUM_REQ_DEFAULT = 3;

   typedef logic [ADDR_W-1:0] regAddr_t;
   typedef logic [DATA_W-1:0] regData_t;

   // A single regfile write as presented on the write port.
   typedef struct packed {
      logic     en;
      regAddr_t addr;
      regData_t data;
   } wbWrite_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the writeback request bus, the issue-side reservation port and the
// regfile write port of regfile_wb_arbiter.
//
// Signals:
//   req_valid/req_ready : per-requester handshake, ready is a one-hot grant
//   req_addr/req_data   : packed per-requester destination and data
//   reserve_valid/addr  : issue logic reserves a destination register
//   reserve_ready       : reservation accepted this cycle
//   busy                : per-register scoreboard
//   write_enable/addr/data : registered regfile write port
//   idle                : no pending reservations and no write in flight
//
// Modports:
//   master : execution units / issue logic / regfile side
//   slave  : the arbiter itself
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
   parameter int NUM_REQ = 3
);
   import crypto_pkg::*;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;

   logic                      reserve_valid;
   logic [ADDR_W-1:0]         reserve_addr;
   logic                      reserve_ready;

   logic [NUM_REGS-1:0]       busy;
   logic                      write_enable;
   logic [ADDR_W-1:0]         write_addr;
   logic [DATA_W-1:0]         write_data;
   logic                      idle;

   modport master (
      output req_valid, req_addr, req_data, reserve_valid, reserve_addr,
      input  req_ready, reserve_ready, busy, write_enable, write_addr,
             write_data, idle
   );

   modport slave (
      input  req_valid, req_addr, req_data, reserve_valid, reserve_addr,
      output req_ready, reserve_ready, busy, write_enable, write_addr,
             write_data, idle
   );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Generic round-robin arbiter. The pointer remembers the most recent grant;
// the search for the next grant starts one past it, so every requester that
// stays valid is served within N grants.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, pointer -> N-1 (index 0 first)
//   valid   : per-requester request
//   advance : move the pointer to the current grant at the next edge
//   grant   : one-hot combinational grant, only ever to a valid requester
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] valid,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   logic [IDX_W-1:0] last_q;
   logic [IDX_W-1:0] last_d;
   logic [IDX_W-1:0] grantIdx;
   logic [IDX_W-1:0] candIdx;
   logic             found;

   // Walk the requesters starting at last+1 (wrapping) and take the first
   // valid one. The pointer itself is tried last, which gives it the lowest
   // priority right after being served.
   always_comb begin
      grant    = '0;
      grantIdx = last_q;
      candIdx  = last_q;
      found    = 1'b0;
      for (int k = 1; k <= N; k++) begin
         candIdx = IDX_W'((int'(last_q) + k) % N);
         if (!found && valid[candIdx]) begin
            found    = 1'b1;
            grantIdx = candIdx;
         end
      end
      if (found) begin
         grant[grantIdx] = 1'b1;
      end
   end

   // The pointer only moves when a grant actually takes effect.
   always_comb begin
      last_d = last_q;
      if (advance && found) begin
         last_d = grantIdx;
      end
   end

   // Reset to N-1 so that requester 0 is the first one searched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= IDX_W'(N - 1);
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Write-port controller for the 32x32 regfile. NUM_REQ writeback requesters
// share the single write port through a round-robin arbiter, and a per-register
// busy scoreboard tracks destinations reserved by issue logic until their
// write commits.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : regfile_wb_arbiter_if.slave (requests, reservations, write port,
//          scoreboard and idle)
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
   import crypto_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   regfile_wb_arbiter_if.slave   bus
);

   logic [NUM_REQ-1:0]  grant;
   logic                anyValid;
   regAddr_t            selAddr;
   regData_t            selData;

   wbWrite_t            wb_q;
   wbWrite_t            wb_d;
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                reserveOk;

   // The write port is never stalled, so the arbiter advances whenever
   // anybody is asking; the grant it produces is the handshake ready.
   assign anyValid = |bus.req_valid;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_rr (
      .clk     (clk),
      .rst     (rst),
      .valid   (bus.req_valid),
      .advance (anyValid),
      .grant   (grant)
   );

   assign bus.req_ready = grant;

   // Unpack the granted requester's address and data. The grant is one-hot,
   // so OR-ing the masked lanes selects exactly one of them.
   always_comb begin
      selAddr = '0;
      selData = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            selAddr = selAddr | bus.req_addr[i*ADDR_W +: ADDR_W];
            selData = selData | bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next regfile write: enable follows the grant, address and data are only
   // loaded on a grant so they hold their last values otherwise.
   always_comb begin
      wb_d    = wb_q;
      wb_d.en = |grant;
      if (|grant) begin
         wb_d.addr = selAddr;
         wb_d.data = selData;
      end
   end

   // A busy register refuses reservations, including the cycle in which its
   // write is committing, so set and clear can never hit the same bit.
   assign reserveOk = !busy_q[bus.reserve_addr];

   // Scoreboard next state: clear the register being committed this edge,
   // then set a newly accepted reservation.
   always_comb begin
      busy_d = busy_q;
      if (wb_q.en) begin
         busy_d[wb_q.addr] = 1'b0;
      end
      if (bus.reserve_valid && reserveOk) begin
         busy_d[bus.reserve_addr] = 1'b1;
      end
   end

   // Write-port and scoreboard registers. Reset drops any write in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_q   <= '0;
         busy_q <= '0;
      end else begin
         wb_q   <= wb_d;
         busy_q <= busy_d;
      end
   end

   assign bus.reserve_ready = reserveOk;
   assign bus.busy          = busy_q;
   assign bus.write_enable  = wb_q.en;
   assign bus.write_addr    = wb_q.addr;
   assign bus.write_data    = wb_q.data;

   // Derived only from registered state, never from inputs.
   assign bus.idle = (busy_q == '0) && !wb_q.en;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter. A behavioural model (grant
// pointer, busy bit-vector and the last write) predicts every cycle; directed
// sequences cover the round-robin order, scoreboard set/clear and an
// asynchronous reset, followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
   import crypto_pkg::*;

   localparam int N = 3;

   logic clk;
   logic rst;

   regfile_wb_arbiter_if #(.NUM_REQ(N)) bus ();

   regfile_wb_arbiter #(
      .NUM_REQ (N)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   int                  mLast;
   logic [NUM_REGS-1:0] mBusy;
   logic                mWe;
   logic [ADDR_W-1:0]   mWaddr;
   logic [DATA_W-1:0]   mWdata;

   // Requester payloads and observations from the latest cycle
   logic [ADDR_W-1:0]   reqAddr [N];
   logic [DATA_W-1:0]   reqData [N];
   logic [N-1:0]        obsReady;
   logic                obsRes;
   int                  lastGrant;

   // Random-phase bookkeeping
   logic [N-1:0]        pend;
   int                  issued  [N];
   int                  granted [N];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic resetModel();
      mLast  = N - 1;
      mBusy  = '0;
      mWe    = 1'b0;
      mWaddr = '0;
      mWdata = '0;
   endtask

   task automatic checkRegs();
      checkOutput("we",    bus.write_enable, mWe);
      checkOutput("waddr", bus.write_addr,   mWaddr);
      checkOutput("wdata", bus.write_data,   mWdata);
      checkOutput("busy",  bus.busy,         mBusy);
      checkOutput("idle",  bus.idle,         (mBusy == '0) && !mWe);
   endtask

   // Called #1 after a rising edge: drive one cycle of inputs, check the
   // combinational outputs, step the model over the edge, check registers.
   task automatic applyStimulus(input logic [N-1:0] v, input logic rv, input logic [ADDR_W-1:0] ra);
      logic [N-1:0] expReady;
      logic         expRes;
      int           g;
      bus.req_valid     = v;
      bus.reserve_valid = rv;
      bus.reserve_addr  = ra;
      for (int i = 0; i < N; i++) begin
         bus.req_addr[i*ADDR_W +: ADDR_W] = reqAddr[i];
         bus.req_data[i*DATA_W +: DATA_W] = reqData[i];
      end
      #1;
      g = -1;
      for (int k = 1; k <= N; k++) begin
         if (g < 0 && v[(mLast + k) % N]) g = (mLast + k) % N;
      end
      expReady = (g < 0) ? '0 : (N'(1) << g);
      expRes   = !mBusy[ra];
      obsReady = bus.req_ready;
      obsRes   = bus.reserve_ready;
      checkOutput("ready",   obsReady, expReady);
      checkOutput("resRdy",  obsRes,   expRes);
      lastGrant = g;
      @(posedge clk);
      if (mWe) mBusy[mWaddr] = 1'b0;
      if (rv && expRes) mBusy[ra] = 1'b1;
      if (g >= 0) begin
         mWe    = 1'b1;
         mWaddr = reqAddr[g];
         mWdata = reqData[g];
         mLast  = g;
      end else begin
         mWe = 1'b0;
      end
      #1;
      checkRegs();
   endtask

   initial begin
      rst               = 1'b1;
      bus.req_valid     = '0;
      bus.req_addr      = '0;
      bus.req_data      = '0;
      bus.reserve_valid = 1'b0;
      bus.reserve_addr  = '0;
      for (int i = 0; i < N; i++) begin
         reqAddr[i] = '0;
         reqData[i] = '0;
         issued[i]  = 0;
         granted[i] = 0;
      end
      pend = '0;
      resetModel();

      #12 rst = 1'b0;
      @(posedge clk);
      #1;
      $display("[TB] reset state");
      checkOutput("rstBusy",  bus.busy, 0);
      checkOutput("rstWe",    bus.write_enable, 0);
      checkOutput("rstIdle",  bus.idle, 1);
      checkOutput("rstResOk", bus.reserve_ready, 1);

      $display("[TB] all requesters valid, round robin");
      for (int i = 0; i < N; i++) begin
         reqAddr[i] = ADDR_W'(i + 1);
         reqData[i] = DATA_W'(32'h100 + i);
      end
      for (int c = 0; c < 6; c++) begin
         applyStimulus(3'b111, 1'b0, '0);
         checkOutput("rrOrder", obsReady, 3'b001 << (c % 3));
         checkOutput("rrAddr",  bus.write_addr, (c % 3) + 1);
      end

      $display("[TB] single write from requester 0");
      reqAddr[0] = 5'd15;
      reqData[0] = 32'd15;
      applyStimulus(3'b001, 1'b0, '0);
      checkOutput("w15Addr", bus.write_addr, 15);
      checkOutput("w15Data", bus.write_data, 15);
      applyStimulus(3'b000, 1'b0, '0);
      checkOutput("w15Done", bus.write_enable, 0);

      $display("[TB] reserve and clear register 1");
      applyStimulus(3'b000, 1'b1, 5'd1);
      checkOutput("res1Set", bus.busy[1], 1);
      reqAddr[1] = 5'd1;
      reqData[1] = 32'd123;
      applyStimulus(3'b010, 1'b1, 5'd1);
      checkOutput("res1Refuse", obsRes, 0);
      checkOutput("w1Data", bus.write_data, 123);
      applyStimulus(3'b000, 1'b1, 5'd1);
      checkOutput("res1Clearing", obsRes, 0);
      checkOutput("res1Cleared", bus.busy[1], 0);
      applyStimulus(3'b000, 1'b1, 5'd1);
      checkOutput("res1Again", obsRes, 1);

      $display("[TB] requester 2 then late requester 0");
      reqAddr[2] = 5'd9;  reqData[2] = 32'h22;
      reqAddr[0] = 5'd10; reqData[0] = 32'h11;
      applyStimulus(3'b101, 1'b0, '0);
      checkOutput("late2", obsReady, 3'b100);
      applyStimulus(3'b001, 1'b0, '0);
      checkOutput("late0", obsReady, 3'b001);
      checkOutput("late0Addr", bus.write_addr, 10);

      $display("[TB] asynchronous reset mid-cycle");
      applyStimulus(3'b000, 1'b1, 5'd3);
      reqAddr[1] = 5'd5; reqData[1] = 32'h55;
      applyStimulus(3'b010, 1'b0, '0);
      checkOutput("preRstWe",   bus.write_enable, 1);
      checkOutput("preRstBusy", bus.busy[3], 1);
      bus.req_valid = '0;
      #2 rst = 1'b1;
      #1;
      checkOutput("asyncWe",   bus.write_enable, 0);
      checkOutput("asyncBusy", bus.busy, 0);
      checkOutput("asyncIdle", bus.idle, 1);
      checkOutput("asyncAddr", bus.write_addr, 0);
      resetModel();
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(3'b111, 1'b0, '0);
      checkOutput("postRstGrant", obsReady, 3'b001);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(0, 99) < 45)) begin
               pend[i]    = 1'b1;
               reqAddr[i] = ADDR_W'($urandom_range(0, 7));
               reqData[i] = $urandom;
               issued[i]++;
            end
         end
         applyStimulus(pend, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)));
         if (lastGrant >= 0) begin
            pend[lastGrant] = 1'b0;
            granted[lastGrant]++;
         end
      end
      for (int i = 0; i < N; i++) begin
         checkOutput("noLost", granted[i] + int'(pend[i]), issued[i]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32x32 `regfile`. It shares the single regfile write port between NUM_REQ writeback requesters (host load, ALU, crypto unit) using round-robin arbitration. It keeps a per-register busy scoreboard: the issue logic reserves a destination register, and the scoreboard clears that reservation when the write commits. It sits between the execution units and `regfile`, and its outputs drive `write_enable`/`write_addr`/`write_data` directly.

## Interface
- NUM_REQ, 3, number of writeback requesters (2..8)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- NUM_REGS, 32, number of registers (2**ADDR_W)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready at a rising edge
- req_addr  in  NUM_REQ*ADDR_W  packed destination addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data, same packing
- reserve_valid  in  1  issue logic requests to mark reserve_addr busy
- reserve_addr  in  ADDR_W  register to reserve
- reserve_ready  out  1  reservation accepted (combinational: !busy[reserve_addr])
- busy  out  NUM_REGS  registered scoreboard, bit r = write to r pending
- write_enable  out  1  to regfile, registered
- write_addr  out  ADDR_W  to regfile, registered
- write_data  out  DATA_W  to regfile, registered
- idle  out  1  busy==0 and write_enable==0

## Operation
- Arbiter: the round-robin pointer `last` holds the index of the most recent grant. Priority search starts at last+1 mod NUM_REQ.
  - req_ready is combinational from req_valid and `last`.
  - At most one bit of req_ready is set.
  - req_ready is never set for a requester whose valid is low.
- Write port is never stalled: whenever any req_valid is high, exactly one grant is issued that cycle.
- On grant of requester g at edge k:
  - write_enable=1, write_addr=req_addr[g], write_data=req_data[g] during cycle k..k+1.
  - `last`=g.
  - With no grant, write_enable=0. write_addr and write_data hold their previous values.
- Scoreboard:
  - Set: reserve_valid&reserve_ready sets busy[reserve_addr] at the edge.
  - Clear: write_enable=1 clears busy[write_addr] at the same edge the regfile commits.
  - Writes to a non-busy register are legal and leave busy unchanged.
  - A reservation of a register that is busy, including one being cleared this cycle, is refused (reserve_ready=0). Set and clear therefore never target the same bit in one cycle.
- Requester protocol: once req_valid is raised, it and its addr/data hold until granted. Violations are undefined.
- Reset (any time, including mid-transfer):
  - busy=0, write_enable=0, write_addr=0, write_data=0.
  - last=NUM_REQ-1, so requester 0 has first priority.
  - The effect is immediate (asynchronous). A grant in flight is dropped.

## Timing
- Grant latency: 0 cycles from req_valid (same-cycle ready).
- Request accepted at edge k → regfile written at edge k+1 → read ports show the new value after edge k+1.
- Busy clears at edge k+1. A reserve of the same register is accepted no earlier than the cycle after edge k+1.
- Throughput: one write per cycle. With all requesters continuously valid, each is granted once every NUM_REQ cycles.
- idle is registered-derived (combinational from busy and write_enable only). It is never derived from inputs.

## Structure
- Shared package `crypto_pkg`: ADDR_W, DATA_W, NUM_REGS constants, shared with `regfile`.
- Sub-module `rr_arbiter`, parameterised by N:
  - ports: clk, rst, valid[N], advance, grant[N] one-hot.
  - `advance` updates the pointer to the granted index.
  - Reusable for read-port sharing later.
- The top level holds the output register, scoreboard flops and packing/unpacking.

## Test plan
- Reset released, no requests → busy=0, write_enable=0, idle=1, reserve_ready=1.
- Requester 0 writes addr 15 data 15 at edge k → write_enable=1, write_addr=15, write_data=15 in the following cycle. `regfile` read0_addr=15 returns 15 after the next edge.
- All 3 requesters valid for 6 cycles with addrs 1/2/3 → grants in order 0,1,2,0,1,2. Each ready is one-hot, and write_addr follows the sequence 1,2,3,1,2,3.
- Reserve addr 1 → busy[1]=1 and a second reserve of 1 gives reserve_ready=0. Requester 1 then writes addr 1 data 123 → busy[1] clears at the commit edge, read1_data=123 follows, and reserve of 1 is accepted the cycle after.
- Request from requester 2 only, with requester 0 raised in the grant cycle → requester 2 granted first, requester 0 granted the next cycle, with no lost or duplicated writes.
- Assert rst mid-cycle while write_enable=1 and busy[3]=1 → write_enable, busy and idle change immediately (0, 0, 1) with no clock edge. The next grant after release goes to requester 0.
